// File: rtl/ones_group_tx_pkg.sv
// Shared definitions for the ones_group_tx transmitter: one-hot state
// encodings, the default group length and counter width helpers.
package ones_group_tx_pkg;

    // One-hot FSM state encoding (kept as plain constants for legacy tools)
    typedef logic [2:0] state_t;

    localparam state_t S_IDLE = 3'b001;
    localparam state_t S_ONE  = 3'b010;
    localparam state_t S_GAP  = 3'b100;

    // Ones emitted per group unless overridden at instantiation
    localparam int GROUP_LEN_DEFAULT = 4;

    // Ones counter must hold groups*GROUP_LEN for every groups value
    function automatic int ones_cnt_width(input int cnt_w, input int group_len);
        return cnt_w + $clog2(group_len);
    endfunction

    // Position-within-group counter width (GROUP_LEN >= 2)
    function automatic int grp_cnt_width(input int group_len);
        return $clog2(group_len);
    endfunction

endpackage

// File: rtl/ones_group_tx_gap_counter.sv
// Loadable down-counter timing the zero cycles between consecutive ones.
// 'last' is high while the count equals one, i.e. in the final gap cycle.
module gap_counter #(
    parameter int GAP_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [GAP_W-1:0] load_val,
    input  logic             en,
    output logic             last
);

    logic [GAP_W-1:0] count_q;
    logic [GAP_W-1:0] count_d;

    // Next count: a load wins over a decrement
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = count_q - GAP_W'(1'b1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register, cleared by the asynchronous reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last = (count_q == GAP_W'(1'b1));

endmodule

// File: rtl/ones_group_tx.sv
// Serial '1' pulse transmitter feeding the one-counting sequence detector.
// Sends groups*GROUP_LEN single-cycle ones, spaced gap+1 cycles apart, and
// pulses group_done in step with the detector's registered flag.
// Optional feature macro: ONES_GROUP_TX_ABORT_EN adds the 'abort' input,
// which ends a running transfer early with a done pulse.
module ones_group_tx
    import ones_group_tx_pkg::*;
#(
    parameter int GROUP_LEN = GROUP_LEN_DEFAULT,
    parameter int CNT_W     = 4,
    parameter int GAP_W     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] groups,
    input  logic [GAP_W-1:0] gap,
`ifdef ONES_GROUP_TX_ABORT_EN
    input  logic             abort,
`endif
    output logic             data,
    output logic             busy,
    output logic             group_done,
    output logic             done
);

    localparam int OW = ones_cnt_width(CNT_W, GROUP_LEN);
    localparam int GW = grp_cnt_width(GROUP_LEN);

    localparam logic [OW-1:0] ONES_ONE = OW'(1'b1);
    localparam logic [GW-1:0] GRP_ONE  = GW'(1'b1);
    localparam logic [GW-1:0] GRP_LAST = GW'(GROUP_LEN - 1);

    state_t           state_q, state_d;
    logic [OW-1:0]    ones_q, ones_d;
    logic [GW-1:0]    grp_q, grp_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             data_q, data_d;
    logic             busy_q, busy_d;
    logic             group_done_q, group_done_d;
    logic             done_q, done_d;

    logic             gap_load_s;
    logic             gap_en_s;
    logic             gap_last_s;
    logic [OW-1:0]    ones_load_s;

    // Total ones for the transfer; width covers the largest groups value
    assign ones_load_s = OW'(groups) * OW'(GROUP_LEN);

    gap_counter #(
        .GAP_W(GAP_W)
    ) u_gap_counter (
        .clk     (clk),
        .rst     (rst),
        .load    (gap_load_s),
        .load_val(gap_q),
        .en      (gap_en_s),
        .last    (gap_last_s)
    );

    // FSM next state, counters and next values of the registered outputs
    always_comb begin
        state_d      = state_q;
        ones_d       = ones_q;
        grp_d        = grp_q;
        gap_d        = gap_q;
        group_done_d = 1'b0;
        done_d       = 1'b0;
        gap_load_s   = 1'b0;
        gap_en_s     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (groups != '0) begin
                        gap_d   = gap;
                        ones_d  = ones_load_s;
                        grp_d   = '0;
                        state_d = S_ONE;
                    end else begin
                        // Empty request: complete at once, nothing on data
                        done_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_ONE: begin
                ones_d = ones_q - ONES_ONE;
                // A wrap of the in-group position marks a finished group
                if (grp_q == GRP_LAST) begin
                    grp_d        = '0;
                    group_done_d = 1'b1;
                end else begin
                    grp_d = grp_q + GRP_ONE;
                end

                if (ones_q == ONES_ONE) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (gap_q == '0) begin
                    state_d = S_ONE;
                end else begin
                    gap_load_s = 1'b1;
                    state_d    = S_GAP;
                end
            end

            S_GAP: begin
                gap_en_s = 1'b1;
                if (gap_last_s) begin
                    state_d = S_ONE;
                end else begin
                    state_d = S_GAP;
                end
            end

            default: begin
                // Illegal encoding: fall back to a clean idle
                state_d = S_IDLE;
                ones_d  = '0;
                grp_d   = '0;
            end
        endcase

`ifdef ONES_GROUP_TX_ABORT_EN
        // Abort overrides normal progress; a partial group is never flagged
        if (abort && (state_q != S_IDLE)) begin
            state_d      = S_IDLE;
            ones_d       = '0;
            grp_d        = '0;
            gap_load_s   = 1'b0;
            gap_en_s     = 1'b0;
            group_done_d = 1'b0;
            done_d       = 1'b1;
        end else begin
            state_d = state_d;
        end
`endif

        // Outputs are registered copies of the state being entered
        data_d = (state_d == S_ONE);
        busy_d = (state_d != S_IDLE);
    end

    // State, counters and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            ones_q       <= '0;
            grp_q        <= '0;
            gap_q        <= '0;
            data_q       <= 1'b0;
            busy_q       <= 1'b0;
            group_done_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ones_q       <= ones_d;
            grp_q        <= grp_d;
            gap_q        <= gap_d;
            data_q       <= data_d;
            busy_q       <= busy_d;
            group_done_q <= group_done_d;
            done_q       <= done_d;
        end
    end

    assign data       = data_q;
    assign busy       = busy_q;
    assign group_done = group_done_q;
    assign done       = done_q;

endmodule

// File: tb/tb_ones_group_tx.sv
// Scoreboard bench for ones_group_tx: each issued transfer pushes its
// expected output events (cycle, data, group_done, done, busy); a monitor
// on the falling edge pops and compares whenever any output is active.
module tb_ones_group_tx;

    localparam int GL = 4;

    typedef struct {
        int   cyc;
        logic d;
        logic gd;
        logic dn;
        logic bz;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [3:0] groups = 4'd0;
    logic [2:0] gap = 3'd0;
    logic       abort = 1'b0;
    logic       data, busy, group_done, done;

    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    ev_t exp_q[$];
    ev_t e;

    ones_group_tx #(
        .GROUP_LEN(GL),
        .CNT_W    (4),
        .GAP_W    (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .groups    (groups),
        .gap       (gap),
`ifdef ONES_GROUP_TX_ABORT_EN
        .abort     (abort),
`endif
        .data      (data),
        .busy      (busy),
        .group_done(group_done),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected events of a transfer accepted at cycle n; ab >= 0 aborts at n+ab
    task automatic model_xfer(input int n, input int g, input int p, input int ab);
        int   ones, last, off, po;
        ev_t  ev;
        if (g == 0) begin
            ev = '{cyc: n + 1, d: 1'b0, gd: 1'b0, dn: 1'b1, bz: 1'b0};
            exp_q.push_back(ev);
            return;
        end
        ones = g * GL;
        last = n + 1 + (ones - 1) * (p + 1);
        for (int c = n + 1; c <= last + 1; c++) begin
            if (ab >= 0 && c == n + ab + 1) begin
                ev = '{cyc: c, d: 1'b0, gd: 1'b0, dn: 1'b1, bz: 1'b0};
                exp_q.push_back(ev);
                break;
            end
            off = c - n - 1;
            po  = c - n - 2;
            ev.cyc = c;
            ev.d   = (c <= last) && (off % (p + 1) == 0);
            ev.gd  = (po >= 0) && (po % (p + 1) == 0) && ((po / (p + 1)) < ones)
                     && (((po / (p + 1)) + 1) % GL == 0);
            ev.dn  = (c == last + 1);
            ev.bz  = (c <= last);
            if (ev.d || ev.gd || ev.dn) exp_q.push_back(ev);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issue a one-cycle start; afterwards scramble groups/gap to prove latching
    task automatic start_xfer(input int g, input int p, input int ab, output int n);
        n      = cyc;
        start  = 1'b1;
        groups = 4'(g);
        gap    = 3'(p);
        model_xfer(n, g, p, ab);
        @(posedge clk);
        #1;
        start  = 1'b0;
        groups = ~4'(g);
        gap    = ~3'(p);
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    // Monitor: pop and compare on every active output cycle
    always @(negedge clk) begin
        if (rst) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL missed_event exp_cyc=%0d now=%0d", exp_q[0].cyc, cyc);
                e = exp_q.pop_front();
            end
            if (data || group_done || done) begin
                checks++;
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    e = exp_q.pop_front();
                    if (data !== e.d || group_done !== e.gd || done !== e.dn || busy !== e.bz) begin
                        failures++;
                        $display("FAIL event cyc=%0d got d/gd/done/busy=%b%b%b%b exp=%b%b%b%b",
                                 cyc, data, group_done, done, busy, e.d, e.gd, e.dn, e.bz);
                    end
                end else begin
                    failures++;
                    $display("FAIL unexpected_event cyc=%0d got d/gd/done/busy=%b%b%b%b",
                             cyc, data, group_done, done, busy);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        int n, n2;
        // Reset values
        #12;
        check1("rst_data", data, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_group_done", group_done, 1'b0);
        check1("rst_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // groups=1 gap=0, ignored re-start at N+3, back-to-back start at N+5
        start_xfer(1, 0, -1, n);
        wait_cyc(n + 3);
        start  = 1'b1;
        groups = 4'd7;
        gap    = 3'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_cyc(n + 5);
        start_xfer(1, 1, -1, n2);
        wait_cyc(n2 + 10);

        // groups=2 gap=2: ones every third cycle, group_done at N+11 and N+23
        start_xfer(2, 2, -1, n);
        wait_cyc(n + 26);

        // groups=0: only a done pulse
        start_xfer(0, 5, -1, n);
        wait_cyc(n + 4);

        // groups=3 gap=1
        start_xfer(3, 1, -1, n);
        wait_cyc(n + 26);

        // Largest request with largest gap
        start_xfer(15, 7, -1, n);
        wait_cyc(n + 476);

        // Reset mid-transfer: outputs clear at once, no done afterwards
        start_xfer(3, 0, -1, n);
        wait_cyc(n + 2);
        rst = 1'b0;
        #1;
        check1("midrst_data", data, 1'b0);
        check1("midrst_busy", busy, 1'b0);
        check1("midrst_group_done", group_done, 1'b0);
        check1("midrst_done", done, 1'b0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        start_xfer(1, 0, -1, n);
        wait_cyc(n + 7);

`ifdef ONES_GROUP_TX_ABORT_EN
        // Abort while idle has no effect
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Abort at N+6 of groups=2 gap=0: done at N+7, single group_done at N+5
        start_xfer(2, 0, 6, n);
        wait_cyc(n + 6);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        wait_cyc(n + 12);
`endif

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL leftover_events got=%0d exp=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
